// File: rtl/mem_access_ctrl_if.sv
// Requester-side handshake and memory-mux control bundle for mem_access_ctrl.
// master = requesters/datapath, slave = the access controller.
interface mem_access_ctrl_if;
  logic       fetch_req;
  logic       ls_req;
  logic       ls_we;
  logic       ls_src;
  logic       exc_req;
  logic [1:0] exc_cause;
  logic [2:0] mem_sel;
  logic       mem_wr;
  logic [2:0] grant;
  logic       fetch_ack;
  logic       ls_ack;
  logic       exc_ack;
  logic       busy;

  modport master (
    output fetch_req, ls_req, ls_we, ls_src, exc_req, exc_cause,
    input  mem_sel, mem_wr, grant, fetch_ack, ls_ack, exc_ack, busy
  );

  modport slave (
    input  fetch_req, ls_req, ls_we, ls_src, exc_req, exc_cause,
    output mem_sel, mem_wr, grant, fetch_ack, ls_ack, exc_ack, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access arbiter/sequencer: grants fetch, load/store or exception-vector reads
// through IDLE/ADDR/WAIT/DONE. Define MEM_ARB_RR_EN to alternate ls/fetch when both pend.
module mem_access_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input logic               clk,
  input logic               reset_n,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(MEM_WAIT);

  state_t     state, state_nxt;
  logic [2:0] grant_p0, sel_p0;
  logic [2:0] grant_p1, sel_p1;
  logic       wr_p1;
  logic [3:0] cnt_q;
`ifdef MEM_ARB_RR_EN
  logic       last_ls;
`endif

  // Arbitration stage: pick one requester and its address source
  always_comb begin
    grant_p0 = 3'b000;
    if (bus.exc_req) grant_p0 = 3'b100;
`ifdef MEM_ARB_RR_EN
    else if (bus.ls_req && bus.fetch_req) grant_p0 = last_ls ? 3'b001 : 3'b010;
`endif
    else if (bus.ls_req) grant_p0 = 3'b010;
    else if (bus.fetch_req) grant_p0 = 3'b001;

    sel_p0 = sel_p1;
    if (grant_p0[2]) begin
      case (bus.exc_cause)
        2'b01:   sel_p0 = 3'b011;
        2'b10:   sel_p0 = 3'b101;
        default: sel_p0 = 3'b000;
      endcase
    end else if (grant_p0[1]) begin
      sel_p0 = bus.ls_src ? 3'b010 : 3'b100;
    end else if (grant_p0[0]) begin
      sel_p0 = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = (state != IDLE);
    bus.mem_sel   = sel_p1;
    bus.grant     = grant_p1;
    bus.mem_wr    = (state == ADDR) && wr_p1;
    bus.fetch_ack = (state == DONE) && grant_p1[0];
    bus.ls_ack    = (state == DONE) && grant_p1[1];
    bus.exc_ack   = (state == DONE) && grant_p1[2];
    case (state)
      IDLE:    if (grant_p0 != 3'b000) state_nxt = ADDR;
      ADDR:    state_nxt = (WAIT_CNT != 4'd0) ? WAIT : DONE;
      WAIT:    if (cnt_q <= 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access stage: grant, mux select and write intent held for the whole access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_p1 <= 3'b000;
      sel_p1   <= 3'b001;
      wr_p1    <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      case (state)
        IDLE: if (grant_p0 != 3'b000) begin
          grant_p1 <= grant_p0;
          sel_p1   <= sel_p0;
          wr_p1    <= grant_p0[1] && bus.ls_we;
        end
        ADDR: cnt_q <= WAIT_CNT;
        WAIT: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        DONE: begin
          grant_p1 <= 3'b000;
          wr_p1    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-served flag: 0 = fetch, 1 = ls; exception grants leave it untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ls <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_p0[1])      last_ls <= 1'b1;
      else if (grant_p0[0]) last_ls <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MEM_WAIT=2 and MEM_WAIT=0) checked each
// cycle against a transaction-level model, plus directed literal expectations.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus0();
  mem_access_ctrl_if bus1();

  mem_access_ctrl #(.MEM_WAIT(2)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  mem_access_ctrl #(.MEM_WAIT(0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  logic       f_req [2];
  logic       l_req [2];
  logic       l_we  [2];
  logic       l_src [2];
  logic       e_req [2];
  logic [1:0] e_cause [2];

  assign bus0.fetch_req = f_req[0];  assign bus1.fetch_req = f_req[1];
  assign bus0.ls_req    = l_req[0];  assign bus1.ls_req    = l_req[1];
  assign bus0.ls_we     = l_we[0];   assign bus1.ls_we     = l_we[1];
  assign bus0.ls_src    = l_src[0];  assign bus1.ls_src    = l_src[1];
  assign bus0.exc_req   = e_req[0];  assign bus1.exc_req   = e_req[1];
  assign bus0.exc_cause = e_cause[0]; assign bus1.exc_cause = e_cause[1];

  logic [2:0] o_sel [2];
  logic [2:0] o_grant [2];
  logic [2:0] o_ack [2];
  logic       o_wr [2];
  logic       o_busy [2];
  assign o_sel[0]   = bus0.mem_sel;  assign o_sel[1]   = bus1.mem_sel;
  assign o_grant[0] = bus0.grant;    assign o_grant[1] = bus1.grant;
  assign o_ack[0]   = {bus0.exc_ack, bus0.ls_ack, bus0.fetch_ack};
  assign o_ack[1]   = {bus1.exc_ack, bus1.ls_ack, bus1.fetch_ack};
  assign o_wr[0]    = bus0.mem_wr;   assign o_wr[1]    = bus1.mem_wr;
  assign o_busy[0]  = bus0.busy;     assign o_busy[1]  = bus1.busy;

  int cmp_n = 0;
  int err_n = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Transaction model: an access lasts W+2 cycles (age 0 = address, age W+1 = completion)
  int         mw [2] = '{2, 0};
  bit         m_act [2];
  int         m_age [2];
  logic [2:0] m_g [2];
  logic [2:0] m_sel [2];
  bit         m_we [2];
  bit         m_last_ls [2];

  task automatic mdl_reset(input int k);
    m_act[k] = 0; m_age[k] = 0; m_g[k] = 3'b000; m_sel[k] = 3'b001;
    m_we[k] = 0; m_last_ls[k] = 0;
  endtask

  task automatic mdl_step(input int k);
    logic [2:0] p;
    if (m_act[k]) begin
      if (m_age[k] == mw[k] + 1) m_act[k] = 0;
      else m_age[k]++;
    end else begin
      p = 3'b000;
      if (e_req[k]) p = 3'b100;
      else if (l_req[k] && f_req[k]) begin
        p = 3'b010;
`ifdef MEM_ARB_RR_EN
        if (m_last_ls[k]) p = 3'b001;
`endif
      end
      else if (l_req[k]) p = 3'b010;
      else if (f_req[k]) p = 3'b001;
      if (p != 3'b000) begin
        m_act[k] = 1; m_age[k] = 0; m_g[k] = p;
        m_we[k] = p[1] && l_we[k];
        if (p[2]) m_sel[k] = (e_cause[k] == 2'd1) ? 3'b011 : (e_cause[k] == 2'd2) ? 3'b101 : 3'b000;
        else if (p[1]) m_sel[k] = l_src[k] ? 3'b010 : 3'b100;
        else m_sel[k] = 3'b001;
        if (p[1]) m_last_ls[k] = 1;
        if (p[0]) m_last_ls[k] = 0;
      end
    end
  endtask

  initial begin
    mdl_reset(0); mdl_reset(1);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) mdl_reset(k);
        chk($sformatf("dut%0d busy", k),  32'(o_busy[k]), 32'(m_act[k]));
        chk($sformatf("dut%0d grant", k), 32'(o_grant[k]), 32'(m_act[k] ? m_g[k] : 3'b000));
        chk($sformatf("dut%0d mem_sel", k), 32'(o_sel[k]), 32'(m_sel[k]));
        chk($sformatf("dut%0d mem_wr", k), 32'(o_wr[k]), 32'(m_act[k] && m_age[k] == 0 && m_we[k]));
        chk($sformatf("dut%0d acks", k), 32'(o_ack[k]),
            32'((m_act[k] && m_age[k] == mw[k] + 1) ? m_g[k] : 3'b000));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) mdl_reset(k);
        else mdl_step(k);
      end
    end
  end

  task automatic go();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      f_req[k] = 0; l_req[k] = 0; l_we[k] = 0; l_src[k] = 0; e_req[k] = 0; e_cause[k] = 2'b00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_sel", 32'(bus0.mem_sel), 32'h1);
    chk("reset busy", 32'(bus0.busy), 32'h0);
    chk("reset grant", 32'(bus0.grant), 32'h0);
    chk("reset acks", 32'(o_ack[0]), 32'h0);
    chk("reset mem_wr", 32'(bus1.mem_wr), 32'h0);
    go();
    reset_n = 1'b1;

    // fetch with MEM_WAIT=2: request placed in the first cycle out of reset
    f_req[0] = 1;
    for (int d = 0; d <= 5; d++) begin
      @(negedge clk);
      chk($sformatf("fetch busy d%0d", d), 32'(bus0.busy), 32'(d >= 1 && d <= 4));
      chk($sformatf("fetch ack d%0d", d), 32'(bus0.fetch_ack), 32'(d == 4));
      if (d >= 1 && d <= 4) chk($sformatf("fetch sel d%0d", d), 32'(bus0.mem_sel), 32'h1);
      if (d == 4) f_req[0] = 0;
    end

    // store via ALUOut
    go();
    l_req[0] = 1; l_we[0] = 1; l_src[0] = 0;
    for (int d = 0; d <= 5; d++) begin
      @(negedge clk);
      chk($sformatf("store wr d%0d", d), 32'(bus0.mem_wr), 32'(d == 1));
      chk($sformatf("store ack d%0d", d), 32'(bus0.ls_ack), 32'(d == 4));
      if (d >= 1 && d <= 4) chk($sformatf("store sel d%0d", d), 32'(bus0.mem_sel), 32'h4);
      if (d == 4) l_req[0] = 0;
    end

    // three simultaneous requesters, exc cause 01
    go();
    e_req[0] = 1; e_cause[0] = 2'b01; l_req[0] = 1; l_we[0] = 0; l_src[0] = 1; f_req[0] = 1;
    for (int d = 0; d <= 15; d++) begin
      logic [2:0] eg;
      logic [2:0] es;
      @(negedge clk);
      eg = (d >= 1 && d <= 4) ? 3'b100 : (d >= 6 && d <= 9) ? 3'b010 :
           (d >= 11 && d <= 14) ? 3'b001 : 3'b000;
      es = (d >= 1 && d <= 5) ? 3'b011 : (d >= 6 && d <= 10) ? 3'b010 : 3'b001;
      chk($sformatf("prio grant d%0d", d), 32'(bus0.grant), 32'(eg));
      if (d >= 1) chk($sformatf("prio sel d%0d", d), 32'(bus0.mem_sel), 32'(es));
      chk($sformatf("prio acks d%0d", d), 32'(o_ack[0]),
          32'((d == 4) ? 3'b100 : (d == 9) ? 3'b010 : (d == 14) ? 3'b001 : 3'b000));
      if (d == 4) e_req[0] = 0;
      if (d == 9) l_req[0] = 0;
      if (d == 14) f_req[0] = 0;
    end

    // exc pulse that vanishes before arbitration; ls dropped after grant still completes
    go();
    l_req[0] = 1; l_we[0] = 0; l_src[0] = 0; e_cause[0] = 2'b10;
    for (int d = 0; d <= 6; d++) begin
      @(negedge clk);
      chk($sformatf("drop ls_ack d%0d", d), 32'(bus0.ls_ack), 32'(d == 4));
      chk($sformatf("drop exc_ack d%0d", d), 32'(bus0.exc_ack), 32'h0);
      if (d >= 5) chk($sformatf("drop busy d%0d", d), 32'(bus0.busy), 32'h0);
      if (d == 2) begin e_req[0] = 1; l_req[0] = 0; end
      if (d == 3) e_req[0] = 0;
    end

    // MEM_WAIT=0 load via register B
    go();
    l_req[1] = 1; l_we[1] = 0; l_src[1] = 1;
    for (int d = 0; d <= 3; d++) begin
      @(negedge clk);
      chk($sformatf("w0 ack d%0d", d), 32'(bus1.ls_ack), 32'(d == 2));
      chk($sformatf("w0 wr d%0d", d), 32'(bus1.mem_wr), 32'h0);
      if (d >= 1) chk($sformatf("w0 sel d%0d", d), 32'(bus1.mem_sel), 32'h2);
      if (d == 2) l_req[1] = 0;
    end

    // reset pulse in WAIT aborts the access with no ack
    go();
    f_req[0] = 1;
    for (int d = 0; d <= 2; d++) @(negedge clk);
    chk("pre-reset busy", 32'(bus0.busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus0.busy), 32'h0);
    chk("abort grant", 32'(bus0.grant), 32'h0);
    chk("abort mem_sel", 32'(bus0.mem_sel), 32'h1);
    chk("abort acks", 32'(o_ack[0]), 32'h0);
    chk("abort sel dut1", 32'(bus1.mem_sel), 32'h1);
    f_req[0] = 0;
    go();
    reset_n = 1'b1;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      chk($sformatf("post-reset ack d%0d", d), 32'(o_ack[0]), 32'h0);
    end

    // ls and fetch held continuously
    go();
    l_req[0] = 1; f_req[0] = 1; l_we[0] = 0; l_src[0] = 0;
    for (int d = 0; d <= 21; d++) begin
      @(negedge clk);
      if (d == 1 || d == 6 || d == 11 || d == 16) begin
`ifdef MEM_ARB_RR_EN
        chk($sformatf("rr grant d%0d", d), 32'(bus0.grant), 32'((((d - 1) / 5) % 2 == 0) ? 3'b010 : 3'b001));
`else
        chk($sformatf("fixed grant d%0d", d), 32'(bus0.grant), 32'h2);
`endif
      end
      if (d >= 20) chk($sformatf("hold end busy d%0d", d), 32'(bus0.busy), 32'h0);
      if (d == 19) begin l_req[0] = 0; f_req[0] = 0; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 2, meaning memory wait cycles per access (legal range 0..15).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 fetch_req  input  1  instruction fetch request; memory address is PC.
REQ-005 ls_req  input  1  load/store request.
REQ-006 ls_we  input  1  1 = store, 0 = load; sampled at grant.
REQ-007 ls_src  input  1  address source: 0 = ALUOut, 1 = register B; sampled at grant.
REQ-008 exc_req  input  1  exception vector read request.
REQ-009 exc_cause  input  2  00 = vector 253, 01 = vector 254, 10 = vector 255, 11 = vector 253; sampled at grant.
REQ-010 mem_sel  output  3  memory address mux selector: 000 = 253, 001 = PC, 010 = register B, 011 = 254, 100 = ALUOut, 101 = 255.
REQ-011 mem_wr  output  1  memory write strobe.
REQ-012 grant  output  3  one-hot active requester {exc, ls, fetch}.
REQ-013 fetch_ack, ls_ack, exc_ack  output  1 each  one-cycle completion pulse to the requester.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement the FSM states IDLE, ADDR, WAIT and DONE.
REQ-016 In IDLE with any request high, the block SHALL grant exactly one requester and enter ADDR on the next edge; with no request it SHALL remain in IDLE.
REQ-017 Default arbitration SHALL be fixed priority: exc > ls > fetch.
REQ-018 On grant, mem_sel SHALL be registered from the granted source and SHALL be held constant from ADDR through DONE.
REQ-019 mem_sel mapping: fetch -> 001; ls with ls_src 0 -> 100; ls with ls_src 1 -> 010; exc causes 00/01/10/11 -> 000/011/101/000.
REQ-020 In IDLE, mem_sel SHALL hold the last driven value.
REQ-021 mem_wr SHALL be high only during the ADDR cycle of an ls grant with ls_we = 1; it SHALL be 0 for every fetch and exc access.
REQ-022 ADDR SHALL go to WAIT when MEM_WAIT > 0, or directly to DONE when MEM_WAIT = 0.
REQ-023 WAIT SHALL last exactly MEM_WAIT cycles, counted by a 4-bit down-counter, then go to DONE.
REQ-024 In DONE, the granted requester's ack SHALL pulse high for one cycle, grant SHALL clear on the next edge, and the FSM SHALL return to IDLE.
REQ-025 Latency: with a request first seen in IDLE at cycle N, the ack SHALL be high in cycle N+2+MEM_WAIT; back-to-back accesses SHALL be separated by one IDLE cycle.
REQ-026 Requesters hold req high until their ack; a request dropped before grant SHALL be ignored, and a request dropped after grant SHALL NOT abort the access.
REQ-027 A request arriving during an access, including exc_req, SHALL NOT preempt it; it SHALL be arbitrated in the next IDLE cycle.
REQ-028 A requester still high in the cycle its ack pulses SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-029 While reset_n is low: state = IDLE, mem_sel = 001, mem_wr = 0, grant = 000, all acks = 0, busy = 0, wait counter = 0.
REQ-030 Reset asserted mid-access SHALL abort the access immediately, issue no ack, and clear all FSM and grant state asynchronously.
REQ-031 After reset deassertion, the first arbitration SHALL occur on the first rising edge with reset_n high.

Configuration
REQ-032 With macro MEM_ARB_RR_EN defined, ls and fetch SHALL alternate whenever both are pending, tracked by a 1-bit last-served flag (reset value: fetch last served, so ls wins first); exc SHALL keep absolute priority.
REQ-033 Without MEM_ARB_RR_EN, arbitration SHALL be the fixed priority in REQ-017 and no round-robin flag SHALL exist.

Verification
REQ-034 MEM_WAIT = 2; fetch_req at cycle 0 -> mem_sel = 001 from cycle 1, fetch_ack high in cycle 4 only, busy high in cycles 1-4.
REQ-035 ls_req with ls_we = 1 and ls_src = 0 -> mem_sel = 100, mem_wr high for exactly one cycle (ADDR), ls_ack high after MEM_WAIT+2 cycles.
REQ-036 exc_req, ls_req and fetch_req asserted together, exc_cause = 01 -> exc is served first with mem_sel = 011, then ls, then fetch, each separated by one IDLE cycle.
REQ-037 MEM_WAIT = 0; ls load with ls_src = 1 -> mem_sel = 010, ls_ack high in cycle N+2, mem_wr stays 0.
REQ-038 reset_n pulsed low during WAIT -> outputs take the REQ-029 values immediately and no ack is issued.
REQ-039 With MEM_ARB_RR_EN, ls_req and fetch_req held high continuously -> grants alternate ls, fetch, ls, fetch; without the macro -> only ls is granted.
